led_scan_ctrl: RTL and testbench
================================

// Module: led_scan_ctrl
// PURPOSE
//  Sequencer for the 3-to-8 active-low LED decoder: drives its 3-bit select so a single lit LED runs across 8 LEDs.
//  Takes a mode switch and two raw push-buttons (run/pause, single-step); debounces buttons; divides clk to a step rate.
//  Sits between board switches/buttons and the decoder; top level forces all LEDs off (8'hFF) when led_en=0.
// PARAMETERS
//  DIV_MAX   24'd12_500_000  clk cycles per advance in RUN (4 Hz @ 50 MHz); legal 2..2^24-1
//  DB_CYCLES 20'd1_000_000   cycles a synchronised button must be stable before accepted (20 ms @ 50 MHz); >=2
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  sw_mode   in   2  raw mode switch: 00 STOP, 01 LEFT, 10 RIGHT, 11 BOUNCE
//  btn_run   in   1  raw run/pause button, active high
//  btn_step  in   1  raw single-step button, active high
//  sel       out  3  select to decoder input (0 = LED7 lit ... 7 = LED0 lit)
//  led_en    out  1  1 = sel valid, LEDs shown; 0 = all LEDs off
//  running   out  1  1 while FSM in RUN
//  tick      out  1  one-cycle pulse on every cycle sel advances (RUN tick or PAUSE step)
// BEHAVIOUR
//  Reset: sel=0, led_en=0, running=0, tick=0, dir=UP, FSM=IDLE, prescaler=0, debouncers idle (level 0).
//  Inputs: sw_mode, btn_run, btn_step each pass 2-FF synchroniser; buttons then debounced; a 0->1 change of
//   debounced level gives a 1-cycle pulse (run_p, step_p). Button press to pulse = 2 + DB_CYCLES (+1) cycles.
//  Prescaler: counts only in RUN; wraps at DIV_MAX-1 and raises adv; cleared to 0 on any entry into RUN.
//  FSM (IDLE, RUN, PAUSE):
//   IDLE : led_en=0, sel=0. run_p and mode!=STOP -> RUN; sel loads start pos (LEFT/BOUNCE 0, RIGHT 7), dir=UP.
//   RUN  : led_en=1, running=1. adv -> advance sel, tick=1. run_p -> PAUSE (sel held).
//   PAUSE: led_en=1, sel held. step_p -> advance once, tick=1. run_p -> RUN.
//   Any state: synced mode==STOP -> IDLE next cycle (sel=0, led_en=0); overrides all other events.
//  Advance rule (uses mode at the advance cycle; a mode change mid-run takes effect on the next advance, sel not reloaded):
//   LEFT: sel+1, 7->0 wrap. RIGHT: sel-1, 0->7 wrap.
//   BOUNCE: dir UP -> sel+1, DOWN -> sel-1; at sel=7 going UP -> 6 and dir=DOWN; at 0 going DOWN -> 1 and dir=UP.
//   dir changes only in BOUNCE advances or reset/IDLE exit; LEFT/RIGHT leave it untouched.
//  Simultaneous events: RUN with run_p and adv same cycle -> PAUSE, no advance, tick=0.
//   PAUSE with run_p and step_p same cycle -> RUN, step dropped. step_p in IDLE/RUN ignored; run_p in IDLE with STOP ignored.
//  Button held: exactly one pulse per press; a bounce shorter than DB_CYCLES never changes debounced level.
//  Async reset mid-operation: outputs go to reset values immediately; first cycle after release is IDLE.
//  All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared header led_scan_defs.vh: mode codes (MODE_STOP/LEFT/RIGHT/BOUNCE), FSM state codes (2-bit),
//   DIR_UP/DIR_DOWN, start positions SEL_FIRST=3'd0, SEL_LAST=3'd7.
//  Sub-module btn_debounce (param DB_CYCLES; ports clk, rst_n, btn_raw, level, rise_p), instanced twice.
//  Top holds mode synchroniser, prescaler, FSM, sel/dir registers.
// TESTING (bench uses DIV_MAX=4, DB_CYCLES=8)
//  Reset, mode=LEFT, press run 20 cycles -> RUN, led_en=1, sel 0,1,..7,0 one step per 4 cycles, tick each advance.
//  mode=BOUNCE from IDLE, run -> sel 0..7,6..0,1 sequence; no repeat of 7 or 0 at turnaround.
//  RUN then run press -> PAUSE, sel frozen >=40 cycles; 3 step presses -> sel advances exactly 3, 3 tick pulses.
//  btn_step toggling every 3 cycles for 30 cycles then stable high -> exactly one step, no extra ticks.
//  mode=RIGHT in RUN at sel=2, switch to STOP -> IDLE within 3 cycles, sel=0, led_en=0; run again -> sel=7.
//  Assert rst_n low mid-RUN with sel=5 -> same-time sel=0, led_en=0, running=0; after release stays IDLE.

Source files
------------

// File: rtl/led_scan_ctrl_pkg.sv
// Shared definitions for the LED scan sequencer: mode codes, FSM states,
// bounce direction, scan end positions and the one-step advance rule.
package led_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [2:0] SEL_FIRST = 3'd0;
    localparam logic [2:0] SEL_LAST  = 3'd7;

    // Scan position: select value plus the bounce direction that goes with it.
    typedef struct packed {
        dir_e       dir;
        logic [2:0] sel;
    } pos_t;

    // Where a fresh run starts: RIGHT scans down from the top, others from 0.
    function automatic logic [2:0] start_sel(input mode_e m);
        return (m == MODE_RIGHT) ? SEL_LAST : SEL_FIRST;
    endfunction

    // One advance of the scan. LEFT/RIGHT wrap and leave dir alone; BOUNCE
    // turns around at the ends without repeating the end position.
    function automatic pos_t advance(input mode_e m, input pos_t p);
        pos_t n;
        n = p;
        case (m)
            MODE_LEFT:  n.sel = p.sel + 3'd1;
            MODE_RIGHT: n.sel = p.sel - 3'd1;
            MODE_BOUNCE: begin
                if (p.dir == DIR_UP) begin
                    if (p.sel == SEL_LAST) begin
                        n.sel = SEL_LAST - 3'd1;
                        n.dir = DIR_DOWN;
                    end else begin
                        n.sel = p.sel + 3'd1;
                    end
                end else begin
                    if (p.sel == SEL_FIRST) begin
                        n.sel = SEL_FIRST + 3'd1;
                        n.dir = DIR_UP;
                    end else begin
                        n.sel = p.sel - 3'd1;
                    end
                end
            end
            default: n = p;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-counter debounce and a
// one-cycle pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
    parameter logic [19:0] DB_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_p
);

    logic [1:0]  sync;
    logic [19:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], btn_raw};
    end

    // Accept a new level only after it has differed from the current one for
    // DB_CYCLES consecutive cycles; any return to the old level restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            level  <= 1'b0;
            rise_p <= 1'b0;
        end else begin
            rise_p <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == DB_CYCLES - 20'd1) begin
                cnt    <= '0;
                level  <= sync[1];
                rise_p <= sync[1];
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan sequencer: drives the 3-bit select of an active-low 3-to-8 decoder
// so a single lit LED runs across 8 LEDs, under mode switch and two buttons.
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter logic [23:0] DIV_MAX   = 24'd12_500_000,
    parameter logic [19:0] DB_CYCLES = 20'd1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw_mode,
    input  logic       btn_run,
    input  logic       btn_step,
    output logic [2:0] sel,
    output logic       led_en,
    output logic       running,
    output logic       tick
);

    localparam int NUM_BTN = 2;

    // Bit 0 is run/pause, bit 1 is single-step. The debounced levels are not
    // needed here, only their rising-edge pulses.
    logic [NUM_BTN-1:0] btn_raw, btn_lvl_unused, btn_rise;
    logic               run_p, step_p;

    assign btn_raw = {btn_step, btn_run};
    assign run_p   = btn_rise[0];
    assign step_p  = btn_rise[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .level  (btn_lvl_unused[i]),
            .rise_p (btn_rise[i])
        );
    end

    logic [1:0] mode_meta;
    mode_e      mode_s;

    // Mode switch synchroniser; resets to STOP so the FSM starts parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta <= 2'b00;
            mode_s    <= MODE_STOP;
        end else begin
            mode_meta <= sw_mode;
            mode_s    <= mode_e'(mode_meta);
        end
    end

    state_e      state;
    pos_t        pos;
    logic [23:0] presc;
    logic        adv;

    // Step-rate strobe, only meaningful while running.
    assign adv = (state == ST_RUN) && (presc == DIV_MAX - 24'd1);
    assign sel = pos.sel;

    // Sequencer FSM with prescaler and registered outputs. STOP overrides
    // everything; run_p beats a same-cycle advance or step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pos     <= '{dir: DIR_UP, sel: SEL_FIRST};
            presc   <= '0;
            led_en  <= 1'b0;
            running <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (mode_s == MODE_STOP) begin
                state   <= ST_IDLE;
                pos.sel <= SEL_FIRST;
                presc   <= '0;
                led_en  <= 1'b0;
                running <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_p) begin
                            state   <= ST_RUN;
                            pos     <= '{dir: DIR_UP, sel: start_sel(mode_s)};
                            presc   <= '0;
                            led_en  <= 1'b1;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (run_p) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else begin
                            presc <= adv ? 24'd0 : presc + 24'd1;
                            if (adv) begin
                                pos  <= advance(mode_s, pos);
                                tick <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (run_p) begin
                            state   <= ST_RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end else if (step_p) begin
                            pos  <= advance(mode_s, pos);
                            tick <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        pos.sel <= SEL_FIRST;
                        led_en  <= 1'b0;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl with DIV_MAX=4, DB_CYCLES=8.
// Expected scan sequences come from simple arithmetic on position/phase.
module tb_led_scan_ctrl;

    localparam int DIV = 4;
    localparam int M_STOP = 0, M_LEFT = 1, M_RIGHT = 2, M_BOUNCE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw_mode = 2'b00;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic [2:0] sel;
    logic       led_en, running, tick;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sel_log[$];
    int tcyc_log[$];

    led_scan_ctrl #(.DIV_MAX(24'd4), .DB_CYCLES(20'd8)) dut (
        .clk(clk), .rst_n(rst_n), .sw_mode(sw_mode), .btn_run(btn_run),
        .btn_step(btn_step), .sel(sel), .led_en(led_en), .running(running),
        .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every advance: the select value it produced and when.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            sel_log.push_back(int'(sel));
            tcyc_log.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference: wrap-around scans and the 14-phase bounce triangle.
    function automatic int lr_next(input int mode, input int s);
        return (mode == M_LEFT) ? (s + 1) % 8 : (s + 7) % 8;
    endfunction

    function automatic int bounce_at(input int phase);
        int p;
        p = phase % 14;
        return (p <= 7) ? p : 14 - p;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_running(input logic want, input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (running === want) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_sel(input int want, input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (sel === 3'(want) && tick === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Press run from IDLE and check the run entry point.
    task automatic start_run(input string nm, input int exp_sel);
        bit ok;
        btn_run = 1'b1;
        wait_running(1'b1, 40, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL %s_enter_run: running never rose", nm); end
        n_chk++;
        if (led_en !== 1'b1) begin n_fail++; $display("FAIL %s_led_en: got %0b expected 1", nm, led_en); end
        n_chk++;
        if (sel !== 3'(exp_sel)) begin n_fail++; $display("FAIL %s_start_sel: got %0d expected %0d", nm, sel, exp_sel); end
        idle($urandom_range(3, 8));
        btn_run = 1'b0;
    endtask

    task automatic go_stop(input string nm);
        sw_mode = 2'(M_STOP);
        idle(5);
        n_chk++;
        if (running !== 1'b0 || led_en !== 1'b0 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_stop: running=%0b led_en=%0b sel=%0d expected 0/0/0", nm, running, led_en, sel);
        end
        idle(15);
    endtask

    task automatic test_reset();
        idle(3);
        n_chk++;
        if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        n_chk++;
        if (led_en !== 1'b0) begin n_fail++; $display("FAIL reset_led_en: got %0b expected 0", led_en); end
        n_chk++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", running); end
        n_chk++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b expected 0", tick); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_left();
        int base, s, nadv;
        sw_mode = 2'(M_LEFT);
        idle(4);
        base = sel_log.size();
        start_run("left", 0);
        nadv = $urandom_range(9, 14);
        idle(nadv * DIV);
        n_chk++;
        if (sel_log.size() - base < 9) begin
            n_fail++;
            $display("FAIL left_tick_count: got %0d expected >=9", sel_log.size() - base);
        end
        s = 0;
        for (int i = base; i < sel_log.size(); i++) begin
            s = lr_next(M_LEFT, s);
            n_chk++;
            if (sel_log[i] != s) begin n_fail++; $display("FAIL left_seq[%0d]: got %0d expected %0d", i - base, sel_log[i], s); end
            if (i > base) begin
                n_chk++;
                if (tcyc_log[i] - tcyc_log[i-1] != DIV) begin
                    n_fail++;
                    $display("FAIL left_period: got %0d expected %0d", tcyc_log[i] - tcyc_log[i-1], DIV);
                end
            end
        end
        go_stop("left");
    endtask

    task automatic test_bounce();
        int base, exp;
        sw_mode = 2'(M_BOUNCE);
        idle(4);
        base = sel_log.size();
        start_run("bounce", 0);
        idle(DIV * $urandom_range(16, 22));
        n_chk++;
        if (sel_log.size() - base < 15) begin
            n_fail++;
            $display("FAIL bounce_tick_count: got %0d expected >=15", sel_log.size() - base);
        end
        for (int i = base; i < sel_log.size(); i++) begin
            exp = bounce_at(i - base + 1);
            n_chk++;
            if (sel_log[i] != exp) begin n_fail++; $display("FAIL bounce_seq[%0d]: got %0d expected %0d", i - base, sel_log[i], exp); end
        end
        go_stop("bounce");
    endtask

    task automatic test_pause_step();
        int base, frozen, exp;
        bit ok;
        sw_mode = 2'(M_LEFT);
        idle(4);
        start_run("pause", 0);
        idle(DIV * $urandom_range(2, 6) + $urandom_range(0, 3));
        btn_run = 1'b1;
        wait_running(1'b0, 40, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL pause_enter: running never fell"); end
        n_chk++;
        if (led_en !== 1'b1) begin n_fail++; $display("FAIL pause_led_en: got %0b expected 1", led_en); end
        frozen = int'(sel);
        base = sel_log.size();
        idle($urandom_range(5, 10));
        btn_run = 1'b0;
        idle(40);
        n_chk++;
        if (sel !== 3'(frozen) || sel_log.size() != base) begin
            n_fail++;
            $display("FAIL pause_frozen: sel=%0d ticks=%0d expected sel=%0d ticks=0", sel, sel_log.size() - base, frozen);
        end
        for (int k = 0; k < 3; k++) begin
            btn_step = 1'b1;
            idle($urandom_range(12, 20));
            btn_step = 1'b0;
            idle(16);
        end
        n_chk++;
        if (sel_log.size() - base != 3) begin
            n_fail++;
            $display("FAIL step_ticks: got %0d expected 3", sel_log.size() - base);
        end
        exp = frozen;
        for (int i = base; i < sel_log.size(); i++) begin
            exp = lr_next(M_LEFT, exp);
            n_chk++;
            if (sel_log[i] != exp) begin n_fail++; $display("FAIL step_seq[%0d]: got %0d expected %0d", i - base, sel_log[i], exp); end
        end
        n_chk++;
        if (sel !== 3'((frozen + 3) % 8)) begin n_fail++; $display("FAIL step_final: got %0d expected %0d", sel, (frozen + 3) % 8); end
    endtask

    // Runs from PAUSE left by the previous test.
    task automatic test_glitch_step();
        int base, s0;
        base = sel_log.size();
        s0 = int'(sel);
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            idle(3);
        end
        btn_step = 1'b1;
        idle(20);
        btn_step = 1'b0;
        idle(16);
        n_chk++;
        if (sel_log.size() - base != 1) begin
            n_fail++;
            $display("FAIL glitch_ticks: got %0d expected 1", sel_log.size() - base);
        end
        n_chk++;
        if (sel !== 3'((s0 + 1) % 8)) begin n_fail++; $display("FAIL glitch_sel: got %0d expected %0d", sel, (s0 + 1) % 8); end
        go_stop("glitch");
    endtask

    task automatic test_right_stop();
        int k;
        bit ok;
        sw_mode = 2'(M_RIGHT);
        idle(4);
        start_run("right", 7);
        wait_sel(2, 100, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL right_reach2: sel never reached 2, now %0d", sel); end
        sw_mode = 2'(M_STOP);
        k = 0;
        while (led_en !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k > 3) begin n_fail++; $display("FAIL stop_latency: got %0d cycles expected <=3", k); end
        n_chk++;
        if (sel !== 3'd0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_state: sel=%0d running=%0b expected 0/0", sel, running);
        end
        idle(5);
        sw_mode = 2'(M_RIGHT);
        idle(4);
        start_run("right_again", 7);
        go_stop("right");
    endtask

    task automatic test_async_reset();
        bit ok;
        sw_mode = 2'(M_LEFT);
        idle(4);
        start_run("areset", 0);
        wait_sel(5, 100, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL areset_reach5: sel never reached 5, now %0d", sel); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (sel !== 3'd0 || led_en !== 1'b0 || running !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: sel=%0d led_en=%0b running=%0b tick=%0b expected all 0", sel, led_en, running, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        n_chk++;
        if (running !== 1'b0 || led_en !== 1'b0 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_idle: running=%0b led_en=%0b sel=%0d expected 0/0/0", running, led_en, sel);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_bounce();
        test_pause_step();
        test_glitch_step();
        test_right_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
